// File: rtl/sort_pkg.sv
// Shared types and the compare/swap decision for the bubble-sort register bank.
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } sort_state_e;

    localparam int SORT_MIN_DEPTH = 2;
    localparam int SORT_MAX_W     = 64;

    // Entries are zero-extended to SORT_MAX_W, so the compare is always unsigned.
    function automatic logic sort_need_swap(input logic [SORT_MAX_W-1:0] a,
                                            input logic [SORT_MAX_W-1:0] b,
                                            input logic                  descend);
        return descend ? (a < b) : (a > b);
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare of one adjacent pair; lo goes to the lower index, hi to the upper.
module sort_cmp_swap
    import sort_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DESCEND = 0
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_swap
);

    assign o_swap = sort_need_swap(SORT_MAX_W'(i_a), SORT_MAX_W'(i_b), DESCEND != 0);
    assign o_lo   = o_swap ? i_b : i_a;
    assign o_hi   = o_swap ? i_a : i_b;

endmodule

// File: rtl/sort_reg_bank.sv
// Addressable register bank that bubble-sorts itself in place, one adjacent pair per clock.
module sort_reg_bank
    import sort_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int DESCEND = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ld,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_data_in,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_q,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W:0]   DEPTH_A   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    sort_state_e       r_state, w_state_nx;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  r_q;
    logic [ADDR_W-1:0] r_idx, r_limit;
    logic              r_swapped;

    logic [ADDR_W-1:0] w_idx1;
    logic [WIDTH-1:0]  w_lo, w_hi;
    logic              w_swap, w_any_swap, w_pass_end;
    logic              w_wr_ok, w_rd_ok, w_start_ok;

    assign w_idx1     = r_idx + ONE;
    assign w_any_swap = r_swapped | w_swap;
    assign w_pass_end = (r_idx >= r_limit - ONE);
    assign w_wr_ok    = i_ld && (r_state != SCAN) && ({1'b0, i_wr_addr} < DEPTH_A);
    assign w_rd_ok    = ({1'b0, i_rd_addr} < DEPTH_A);
    assign w_start_ok = i_start && (r_state == IDLE);
    assign o_q        = r_q;

    sort_cmp_swap #(.WIDTH(WIDTH), .DESCEND(DESCEND)) u_cmp (
        .i_a    (r_mem[r_idx]),
        .i_b    (r_mem[w_idx1]),
        .o_lo   (w_lo),
        .o_hi   (w_hi),
        .o_swap (w_swap)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (r_state)
            IDLE:   if (i_start) w_state_nx = SCAN;
            SCAN: begin
                o_busy = 1'b1;
                if (w_pass_end && (!w_any_swap || r_limit == ONE)) w_state_nx = FINISH;
            end
            FINISH: begin
                o_done     = 1'b1;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_q       <= '0;
            r_idx     <= '0;
            r_limit   <= '0;
            r_swapped <= 1'b0;
        end else begin
            r_q <= w_rd_ok ? r_mem[i_rd_addr] : '0;
            // A load in the start cycle lands at the same edge, so the sort sees it.
            if (w_wr_ok) r_mem[i_wr_addr] <= i_data_in;
            if (w_start_ok) begin
                r_idx     <= '0;
                r_limit   <= LIMIT_MAX;
                r_swapped <= 1'b0;
            end
            if (r_state == SCAN) begin
                r_mem[r_idx]  <= w_lo;
                r_mem[w_idx1] <= w_hi;
                if (!w_pass_end) begin
                    r_idx     <= r_idx + ONE;
                    r_swapped <= w_any_swap;
                end else begin
                    r_idx     <= '0;
                    r_limit   <= r_limit - ONE;
                    r_swapped <= 1'b0;
                end
            end
        end
    end

endmodule
